// File: rtl/fetch_ctl.sv
// fetch_ctl: instruction-fetch sequencer.
// Owns the fetch PC, issues in-order word requests to instruction memory under a
// credit limit, buffers returned words tagged with their PC, and hands them to
// decode. A redirect flushes the buffer and schedules stale responses for discard.
module fetch_ctl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW+1:0] DEPTH_W = DEPTH[CW+1:0];

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]   fifo_rd_q, fifo_rd_d;
  logic [AW-1:0]   fifo_wr_q, fifo_wr_d;
  logic [AW-1:0]   ipq_rd_q, ipq_rd_d;
  logic [AW-1:0]   ipq_wr_q, ipq_wr_d;
  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [XLEN-1:0] fifo_data_d [DEPTH];
  logic [XLEN-1:0] fifo_pc_q   [DEPTH];
  logic [XLEN-1:0] fifo_pc_d   [DEPTH];
  logic [XLEN-1:0] ipq_pc_q    [DEPTH];
  logic [XLEN-1:0] ipq_pc_d    [DEPTH];

  logic [CW+1:0] credit_use;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_drop;
  logic          inst_pop;
  logic          unused_redirect_lo;

  // Word alignment discards the low target bits.
  assign unused_redirect_lo = ^redirect_pc[1:0];

  // Request/decode handshake decode; credits cover in-flight, buffered and to-be-dropped words.
  always_comb begin
    credit_use     = {2'b00, out_cnt_q} + {2'b00, fifo_cnt_q} + {2'b00, drop_cnt_q};
    imem_req_valid = !rst && !redirect_valid && (credit_use < DEPTH_W);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
    rsp_take       = imem_rsp_valid && (drop_cnt_q == '0);
    inst_valid     = (fifo_cnt_q != '0);
    inst_out       = fifo_data_q[fifo_rd_q];
    inst_pc        = fifo_pc_q[fifo_rd_q];
    inst_pop       = inst_valid && inst_ready;
  end

  // Next-state: redirect overrides every other event in its cycle.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    out_cnt_d   = out_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    fifo_cnt_d  = fifo_cnt_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_wr_d   = fifo_wr_q;
    ipq_rd_d    = ipq_rd_q;
    ipq_wr_d    = ipq_wr_q;
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    ipq_pc_d    = ipq_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      fifo_cnt_d = '0;
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      ipq_rd_d   = '0;
      ipq_wr_d   = '0;
      out_cnt_d  = '0;
      // A response arriving now is discarded whichever counter it was charged to.
      drop_cnt_d = drop_cnt_q + out_cnt_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        ipq_pc_d[ipq_wr_q] = fetch_pc_q;
        ipq_wr_d           = ipq_wr_q + AW'(1);
        fetch_pc_d         = fetch_pc_q + XLEN'(4);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (rsp_take) begin
        fifo_data_d[fifo_wr_q] = imem_rsp_data;
        fifo_pc_d[fifo_wr_q]   = ipq_pc_q[ipq_rd_q];
        fifo_wr_d              = fifo_wr_q + AW'(1);
        ipq_rd_d               = ipq_rd_q + AW'(1);
      end
      if (inst_pop) begin
        fifo_rd_d = fifo_rd_q + AW'(1);
      end
      out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp_take);
      fifo_cnt_d = fifo_cnt_q + CW'(rsp_take) - CW'(inst_pop);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      out_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      fifo_cnt_q  <= '0;
      fifo_rd_q   <= '0;
      fifo_wr_q   <= '0;
      ipq_rd_q    <= '0;
      ipq_wr_q    <= '0;
      fifo_data_q <= '{default: '0};
      fifo_pc_q   <= '{default: '0};
      ipq_pc_q    <= '{default: '0};
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      out_cnt_q   <= out_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      fifo_cnt_q  <= fifo_cnt_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_wr_q   <= fifo_wr_d;
      ipq_rd_q    <= ipq_rd_d;
      ipq_wr_q    <= ipq_wr_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
      ipq_pc_q    <= ipq_pc_d;
    end
  end

  // A response with nothing in flight or pending discard means the memory broke ordering.
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((out_cnt_q != '0) || (drop_cnt_q != '0)));

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed bench for fetch_ctl with an in-order memory model and a scoreboard of
// expected {pc, data} entries; a second instance covers a high RESET_PC that wraps.
module tb_fetch_ctl;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_out, inst_pc;

  logic        hi_req_valid;
  logic [31:0] hi_req_addr;
  logic        hi_rsp_valid;
  logic [31:0] hi_rsp_data;
  logic        hi_inst_valid;
  logic [31:0] hi_inst_out, hi_inst_pc;

  always #5 clk = ~clk;

  fetch_ctl #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc)
  );

  fetch_ctl #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut_hi (
    .clk(clk), .rst(rst),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(hi_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(hi_req_addr),
    .imem_rsp_valid(hi_rsp_valid), .imem_rsp_data(hi_rsp_data),
    .inst_valid(hi_inst_valid), .inst_ready(1'b1),
    .inst_out(hi_inst_out), .inst_pc(hi_inst_pc)
  );

  typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;

  mreq_t       mem_q [$];
  inst_t       exp_q [$];
  logic [31:0] hi_addrs [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          mem_lat = 1;
  logic        mem_ready = 1'b1;
  logic [31:0] exp_pc = 32'h0;
  logic        hi_hs_prev = 1'b0;
  logic [31:0] hi_prev_addr = 32'h0;

  function automatic logic [31:0] mdata(logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]} ^ 32'h0000_00A5;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: present memory response, check outputs, advance, update model.
  task automatic step();
    logic        hs, pop, rsp, redir, hi_hs;
    logic [31:0] rpc, hi_addr;
    mreq_t       m;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    imem_req_ready = mem_ready;
    hi_rsp_valid   = hi_hs_prev;
    hi_rsp_data    = hi_prev_addr;
    #2;
    redir = redirect_valid;
    rpc   = redirect_pc;
    chk("req_valid", {31'b0, imem_req_valid},
        {31'b0, !redir && (mem_q.size() + exp_q.size() < DEPTH)});
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_q.size() != 0});
    if (inst_valid && exp_q.size() != 0) begin
      chk("inst_pc", inst_pc, exp_q[0].pc);
      chk("inst_out", inst_out, exp_q[0].data);
    end
    if (hi_inst_valid) chk("hi_inst_tag", hi_inst_out, hi_inst_pc);
    hs      = imem_req_valid && imem_req_ready;
    pop     = inst_valid && inst_ready;
    rsp     = imem_rsp_valid;
    hi_hs   = hi_req_valid;
    hi_addr = hi_req_addr;
    @(posedge clk);
    cyc++;
    if (rsp) begin
      m = mem_q.pop_front();
      if (!redir && m.epoch == epoch) exp_q.push_back('{pc: m.addr, data: mdata(m.addr)});
    end
    if (redir) begin
      epoch++;
      exp_q.delete();
      exp_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (hs) begin
        mem_q.push_back('{addr: exp_pc, due: cyc + mem_lat - 1, epoch: epoch});
        exp_pc = exp_pc + 32'd4;
      end
    end
    hi_hs_prev   = hi_hs;
    hi_prev_addr = hi_addr;
    if (hi_hs) hi_addrs.push_back(hi_addr);
    #1;
  endtask

  // Hold reset for two edges, then release one time unit after an edge.
  task automatic hold_reset();
    rst            = 1'b1;
    imem_rsp_valid = 1'b0;
    hi_rsp_valid   = 1'b0;
    mem_q.delete();
    exp_q.delete();
    hi_addrs.delete();
    exp_pc     = 32'h0;
    hi_hs_prev = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_hi_req_valid", {31'b0, hi_req_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_hi_wrap();
    chk("hi_req_count", {31'b0, hi_addrs.size() >= 3}, 32'h1);
    if (hi_addrs.size() >= 3) begin
      chk("hi_addr0", hi_addrs[0], 32'hFFFF_FFF8);
      chk("hi_addr1", hi_addrs[1], 32'hFFFF_FFFC);
      chk("hi_addr2", hi_addrs[2], 32'h0000_0000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    hi_rsp_valid   = 1'b0;
    hi_rsp_data    = 32'h0;
    inst_ready     = 1'b1;
    hold_reset();

    // Streaming: always-ready memory, latency 1, decode always ready.
    repeat (12) step();
    check_hi_wrap();

    // Back-pressure from decode fills the buffer with 0x0/0x4, then drains.
    hold_reset();
    inst_ready = 1'b0;
    repeat (6) step();
    chk("bp_req_stalled", {31'b0, imem_req_valid}, 32'h0);
    chk("bp_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    repeat (8) step();

    // Redirect with two requests in flight at latency 3.
    mem_lat = 3;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) step();
    chk("setup_two_inflight", mem_q.size(), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    repeat (14) step();

    // Redirect coinciding with a response and a decode pop.
    mem_lat = 1;
    for (int i = 0; i < 20 && !(exp_q.size() != 0 && mem_q.size() != 0 && mem_q[0].due <= cyc); i++)
      step();
    chk("setup_rsp_and_pop", {31'b0, exp_q.size() != 0 && mem_q.size() != 0}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    chk("flush_empty", {31'b0, inst_valid}, 32'h0);
    chk("post_redirect_addr", imem_req_addr, 32'h0000_0200);
    repeat (6) step();

    // Back-to-back redirects with drops pending; unaligned target; then wrap.
    mem_lat = 3;
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    step();
    redirect_pc    = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    chk("unaligned_target", imem_req_addr, 32'h0000_0100);
    repeat (10) step();
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    repeat (12) step();

    // Asynchronous reset mid-cycle with the buffer full.
    inst_ready = 1'b0;
    repeat (6) step();
    chk("full_before_rst", {31'b0, inst_valid}, 32'h1);
    inst_ready = 1'b1;
    #3;
    hold_reset();
    repeat (10) step();
    check_hi_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctl.md
Name: fetch_ctl

Overview:
Instruction-fetch sequencer that consumes the next-PC stream. It owns the architectural fetch PC register and issues in-order word requests to instruction memory over a valid/ready request channel. It buffers returned instructions, tagged with their PC, in a small FIFO and presents them to decode with valid/ready. A redirect from the next-PC logic (taken branch or jump) flushes the buffer and discards stale in-flight responses.

Parameters:
XLEN, 32, address/data width
RESET_PC, 0, fetch PC after reset
DEPTH, 2, instruction FIFO entries; also the maximum number of in-flight requests (power of 2, ≥2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
redirect_valid  in  1  next-PC logic redirects fetch this cycle
redirect_pc  in  XLEN  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word address of request
imem_rsp_valid  in  1  response valid; always accepted, no ready
imem_rsp_data  in  XLEN  instruction word
inst_valid  out  1  decode-side instruction valid
inst_ready  in  1  decode accepts instruction
inst_out  out  XLEN  instruction word at FIFO head
inst_pc  out  XLEN  PC of inst_out

Behaviour:
- Reset (async assert): fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; inst_valid=0. imem_req_valid=0 while rst is high. Memory is reset by the same rst; no responses arrive after reset for pre-reset requests.
- Credit rule: imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count + drop_cnt < DEPTH). This guarantees a response never meets a full FIFO.
- imem_req_addr = fetch_pc. On handshake (valid&ready): push fetch_pc into the in-flight PC queue, outstanding+1, fetch_pc += 4 (mod 2^XLEN, so 0xFFFFFFFC wraps to 0).
- Responses return in request order, minimum latency 1 cycle after handshake.
- On imem_rsp_valid: if drop_cnt>0, decrement drop_cnt and discard. Otherwise pop the PC queue, push {data, pc} into the FIFO, and decrement outstanding.
- inst_valid = FIFO non-empty; inst_out/inst_pc come from the head, registered storage, no combinational path from imem_rsp. Pop on inst_valid&inst_ready. Head stays stable while inst_ready=0.
- Minimum latency from response to inst_valid is 1 cycle (response written on edge, visible next cycle).
- Simultaneous push+pop on a full FIFO is legal; the count is unchanged.
- Redirect (redirect_valid=1), with priority over all other events this cycle:
  - fetch_pc ← {redirect_pc[XLEN-1:2],2'b00}; low two bits are ignored.
  - FIFO flushed and PC queue cleared; any pop this cycle is ignored.
  - drop_cnt ← drop_cnt + outstanding − (1 if imem_rsp_valid this cycle, discarded); outstanding ← 0.
  - No request is issued in the redirect cycle. First post-redirect request is the next cycle.
- Back-to-back redirects: the last one wins; drop accounting accumulates correctly.
- Counters are clog2(DEPTH)+1 bits and never overflow or underflow by construction. An assertion must flag imem_rsp_valid when outstanding+drop_cnt==0.

Test Plan:
- Reset release, memory always ready with 1-cycle latency, inst_ready=1 -> request addrs 0x0,0x4,0x8…; inst_pc 0x0,0x4,0x8 with matching data; inst_valid first seen 2 cycles after the first handshake.
- inst_ready=0 -> after DEPTH=2 requests imem_req_valid stays 0; FIFO holds pc 0x0,0x4 stable. Set inst_ready=1 -> 0x0 then 0x4 drain and requests resume at 0x8.
- Redirect to 0x100 with 2 requests outstanding and memory latency 3 -> both stale responses dropped; next inst_pc=0x100, then 0x104; no inst_valid for stale data.
- Redirect in the same cycle as a response and a decode pop -> response discarded, FIFO empty next cycle, next request addr = target.
- redirect_pc=0x102 -> imem_req_addr 0x100. RESET_PC=0xFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- Assert rst mid-stream with FIFO full -> inst_valid=0 and imem_req_valid=0 immediately (async). After release, first request is at RESET_PC.
